quat_sync_rx: RTL and testbench

- Clocked receiver for the 1-of-4 (quaternary) NCL link driven by the binary+trinary quaternary adder.
- Replaces the free-running TH14 auto-consume with a real consumer:
  - synchronises the asynchronous rails;
  - detects DATA and NULL wavefronts and drives the completion signal back to the NCL stage;
  - delivers each quaternary digit as a 2-bit binary value on a clocked valid/ready stream through a 2-entry buffer.
- Sits at the NCL-to-synchronous boundary of the interaction sandbox.

---
 rtl/quat_sync_rx_pkg.sv | 21 ++
 rtl/quat_sync_rx_if.sv | 10 +
 rtl/quat_sync_rx_rail_sync.sv | 38 +++
 rtl/quat_sync_rx.sv | 79 +++++++
 tb/tb_quat_sync_rx.sv | 151 +++++++++++++++
 5 files changed

// File: rtl/quat_sync_rx_pkg.sv
// quat_sync_rx_pkg: shared NCL rail codes, receiver FSM states and rail-code classification.
package quat_sync_rx_pkg;
  localparam logic [3:0] QUAT_NULL = 4'b0000;
  localparam logic [3:0] QUAT_D0   = 4'b0001;
  localparam logic [3:0] QUAT_D1   = 4'b0010;
  localparam logic [3:0] QUAT_D2   = 4'b0100;
  localparam logic [3:0] QUAT_D3   = 4'b1000;
  typedef enum logic [1:0] {WAIT_DATA, WAIT_SPACE, WAIT_NULL} state_t;
  typedef enum logic [1:0] {CODE_NULL, CODE_DATA, CODE_ILLEGAL} kind_t;
  typedef struct packed {
    kind_t      kind;
    logic [1:0] idx;
  } code_t;
  // idx is only meaningful when kind is CODE_DATA
  function automatic code_t classify(input logic [3:0] r);
    code_t c;
    c.kind = r == QUAT_NULL ? CODE_NULL : $countones(r) == 1 ? CODE_DATA : CODE_ILLEGAL;
    c.idx  = r == QUAT_D3 ? 2'd3 : r == QUAT_D2 ? 2'd2 : r == QUAT_D1 ? 2'd1 : 2'd0;
    return c;
  endfunction
endpackage

// File: rtl/quat_sync_rx_if.sv
// quat_sync_rx_if: NCL rail/completion pair plus the clocked digit stream.
interface quat_sync_rx_if;
  logic [3:0] quat_in;
  logic       quat_comp;
  logic [1:0] out_data;
  logic       out_valid;
  logic       out_ready;
  modport master (input quat_in, out_ready, output quat_comp, out_data, out_valid);
  modport slave  (output quat_in, out_ready, input quat_comp, out_data, out_valid);
endinterface

// File: rtl/quat_sync_rx_rail_sync.sv
// ncl_rail_sync: per-rail synchroniser plus stability filter emitting the accepted code.
module ncl_rail_sync #(
  parameter int RAILS       = 4,
  parameter int SYNC_STAGES = 2,
  parameter int STABLE_CYC  = 2
) (
  input  logic             clk,
  input  logic             init_n,
  input  logic [RAILS-1:0] rails,
  output logic [RAILS-1:0] code,
  output logic             stb
);
  localparam int CW = $clog2(STABLE_CYC + 1);
  logic [RAILS-1:0] sync [SYNC_STAGES];
  logic [RAILS-1:0] s, last;
  logic [CW-1:0] cnt, cnt_nx;
  logic stable;
  assign s      = sync[SYNC_STAGES-1];
  assign cnt_nx = s != last ? CW'(1) : cnt == CW'(STABLE_CYC) ? cnt : cnt + 1'b1;
  assign stable = cnt_nx == CW'(STABLE_CYC);
  // stb pulses only when the accepted code actually changes, so a glitch that
  // returns to the same code is never re-announced
  always_ff @(posedge clk or negedge init_n)
    if (!init_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync[i] <= '0;
      last <= '0;
      cnt  <= '0;
      code <= '0;
      stb  <= 1'b0;
    end else begin
      sync[0] <= rails;
      for (int i = 1; i < SYNC_STAGES; i++) sync[i] <= sync[i-1];
      last <= s;
      cnt  <= cnt_nx;
      stb  <= stable && s != code;
      if (stable) code <= s;
    end
endmodule

// File: rtl/quat_sync_rx.sv
// quat_sync_rx: clocked consumer for a 1-of-4 NCL link feeding a 2-entry FWFT digit stream.
module quat_sync_rx
  import quat_sync_rx_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int STABLE_CYC  = 2,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             init_n,
  quat_sync_rx_if.master   bus,
  output logic [CNT_W-1:0] digit_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic             err_sticky
);
  logic [3:0] code;
  logic stb;
  code_t c;
  state_t state, state_nx;
  logic [1:0] mem [2];
  logic [1:0] cnt, dig, push_dat;
  logic wp, rp, full, push, pop;
  ncl_rail_sync #(.RAILS(4), .SYNC_STAGES(SYNC_STAGES), .STABLE_CYC(STABLE_CYC)) u_sync (
    .clk(clk), .init_n(init_n), .rails(bus.quat_in), .code(code), .stb(stb)
  );
  assign c             = classify(code);
  assign full          = cnt == 2'd2;
  assign pop           = bus.out_valid & bus.out_ready;
  assign bus.out_valid = cnt != 2'd0;
  assign bus.out_data  = mem[rp];
  always_comb begin
    state_nx = state;
    push     = 1'b0;
    push_dat = c.idx;
    case (state)
      WAIT_DATA: if (c.kind == CODE_DATA) begin
        push     = !full;
        state_nx = full ? WAIT_SPACE : WAIT_NULL;
      end
      WAIT_SPACE: begin
        push_dat = dig;
        push     = !full || pop;
        state_nx = push ? WAIT_NULL : WAIT_SPACE;
      end
      WAIT_NULL: state_nx = c.kind == CODE_NULL ? WAIT_DATA : WAIT_NULL;
      default:   state_nx = WAIT_DATA;
    endcase
  end
  // a push into a full buffer is only legal alongside a pop, which frees slot rp == wp
  always_ff @(posedge clk or negedge init_n)
    if (!init_n) begin
      state         <= WAIT_DATA;
      bus.quat_comp <= 1'b0;
      mem[0]        <= '0;
      mem[1]        <= '0;
      wp            <= 1'b0;
      rp            <= 1'b0;
      cnt           <= '0;
      dig           <= '0;
      digit_cnt     <= '0;
      err_cnt       <= '0;
      err_sticky    <= 1'b0;
    end else begin
      state         <= state_nx;
      bus.quat_comp <= state_nx == WAIT_NULL;
      if (state == WAIT_DATA) dig <= c.idx;
      if (push) begin
        mem[wp]   <= push_dat;
        wp        <= !wp;
        digit_cnt <= digit_cnt + 1'b1;
      end
      if (pop) rp <= !rp;
      cnt <= cnt + {1'b0, push} - {1'b0, pop};
      if (stb && c.kind == CODE_ILLEGAL) begin
        err_sticky <= 1'b1;
        if (~&err_cnt) err_cnt <= err_cnt + 1'b1;
      end
    end
endmodule

// File: tb/tb_quat_sync_rx.sv
// tb_quat_sync_rx: directed stimulus with a digit scoreboard drained by a stream monitor.
module tb_quat_sync_rx;
  logic clk = 1'b0;
  logic init_n = 1'b0;
  logic [15:0] digit_cnt, err_cnt;
  logic err_sticky;
  int passed = 0;
  int total = 0;
  int q[$];
  quat_sync_rx_if bus();
  quat_sync_rx #(.SYNC_STAGES(2), .STABLE_CYC(2), .CNT_W(16)) dut (
    .clk(clk), .init_n(init_n), .bus(bus),
    .digit_cnt(digit_cnt), .err_cnt(err_cnt), .err_sticky(err_sticky)
  );
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  always @(negedge clk)
    if (init_n && bus.out_valid && bus.out_ready) begin
      if (q.size() == 0) chk("unexpected_digit", int'(bus.out_data), -1);
      else chk("stream_digit", int'(bus.out_data), q.pop_front());
    end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_comp(input logic v, input string nm);
    int n = 0;
    while (bus.quat_comp !== v && n < 40) begin
      cyc(1);
      n++;
    end
    chk(nm, int'(bus.quat_comp), int'(v));
  endtask

  task automatic digit(input logic [3:0] v, input int idx);
    q.push_back(idx);
    bus.quat_in = v;
    wait_comp(1'b1, "comp_rise");
    bus.quat_in = 4'b0000;
    wait_comp(1'b0, "comp_fall");
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 40) begin
      cyc(1);
      n++;
    end
    chk("drain", q.size(), 0);
  endtask

  initial begin
    bus.quat_in = 4'b0000;
    bus.out_ready = 1'b1;
    cyc(3);
    chk("rst_comp", int'(bus.quat_comp), 0);
    chk("rst_valid", int'(bus.out_valid), 0);
    chk("rst_data", int'(bus.out_data), 0);
    chk("rst_digit_cnt", int'(digit_cnt), 0);
    chk("rst_err_cnt", int'(err_cnt), 0);
    chk("rst_sticky", int'(err_sticky), 0);
    init_n = 1'b1;
    cyc(3);
    // single digit with exact latency
    q.push_back(2);
    bus.quat_in = 4'b0100;
    cyc(4);
    chk("lat_comp_c4", int'(bus.quat_comp), 0);
    cyc(1);
    chk("lat_comp_c5", int'(bus.quat_comp), 1);
    chk("lat_valid_c5", int'(bus.out_valid), 1);
    bus.quat_in = 4'b0000;
    cyc(4);
    chk("null_comp_c4", int'(bus.quat_comp), 1);
    cyc(1);
    chk("null_comp_c5", int'(bus.quat_comp), 0);
    chk("single_digit_cnt", int'(digit_cnt), 1);
    // full sequence
    digit(4'b1000, 3);
    digit(4'b0001, 0);
    digit(4'b0010, 1);
    digit(4'b0100, 2);
    drain();
    chk("seq_digit_cnt", int'(digit_cnt), 5);
    chk("seq_err_cnt", int'(err_cnt), 0);
    // backpressure: two digits fill the buffer, third waits for space
    bus.out_ready = 1'b0;
    digit(4'b0010, 1);
    digit(4'b1000, 3);
    q.push_back(2);
    bus.quat_in = 4'b0100;
    cyc(15);
    chk("bp_comp_held", int'(bus.quat_comp), 0);
    chk("bp_valid", int'(bus.out_valid), 1);
    chk("bp_data_held", int'(bus.out_data), 1);
    chk("bp_digit_cnt", int'(digit_cnt), 7);
    bus.out_ready = 1'b1;
    wait_comp(1'b1, "bp_comp_rise");
    bus.quat_in = 4'b0000;
    wait_comp(1'b0, "bp_comp_fall");
    drain();
    chk("bp_digit_cnt_after", int'(digit_cnt), 8);
    // illegal two-hot code
    bus.quat_in = 4'b0110;
    cyc(10);
    chk("ill_err_cnt", int'(err_cnt), 1);
    chk("ill_sticky", int'(err_sticky), 1);
    chk("ill_comp", int'(bus.quat_comp), 0);
    chk("ill_valid", int'(bus.out_valid), 0);
    chk("ill_digit_cnt", int'(digit_cnt), 8);
    digit(4'b0010, 1);
    drain();
    chk("post_ill_digit_cnt", int'(digit_cnt), 9);
    chk("post_ill_err_cnt", int'(err_cnt), 1);
    // single-cycle glitch
    bus.quat_in = 4'b0001;
    cyc(1);
    bus.quat_in = 4'b0000;
    cyc(10);
    chk("glitch_valid", int'(bus.out_valid), 0);
    chk("glitch_comp", int'(bus.quat_comp), 0);
    chk("glitch_digit_cnt", int'(digit_cnt), 9);
    // asynchronous reset while waiting for NULL; the buffered digit is abandoned
    bus.out_ready = 1'b0;
    bus.quat_in = 4'b1000;
    wait_comp(1'b1, "pre_rst_comp");
    chk("pre_rst_valid", int'(bus.out_valid), 1);
    #2 init_n = 1'b0;
    #1;
    chk("arst_comp", int'(bus.quat_comp), 0);
    chk("arst_valid", int'(bus.out_valid), 0);
    chk("arst_digit_cnt", int'(digit_cnt), 0);
    chk("arst_err_cnt", int'(err_cnt), 0);
    chk("arst_sticky", int'(err_sticky), 0);
    bus.quat_in = 4'b0000;
    cyc(2);
    init_n = 1'b1;
    cyc(2);
    chk("final_queue", q.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
